// File: rtl/store_buffer.sv
// store_buffer: in-order word store FIFO between the Memory stage and a valid/ready data memory, with youngest-store load forwarding
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   MemWriteM            Memory-stage store request
//   ALUResultM           byte address shared by loads and stores ([1:0] ignored)
//   WriteDataM           store data
//   ReadDataM            load data to the core (forwarded or mem_rdata), combinational
//   StallM               store request while the buffer is full
//   sb_empty             no pending stores
//   mem_we/mem_waddr/mem_wdata  head entry write request, held until mem_ready
//   mem_ready            memory accepts the head write this cycle
//   mem_raddr/mem_rdata  word-aligned load address and asynchronous read data
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemWriteM,
  input  logic [AW-1:0] ALUResultM,
  input  logic [31:0]   WriteDataM,
  output logic [31:0]   ReadDataM,
  output logic          StallM,
  output logic          sb_empty,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-3:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          full, enq, deq;
  logic [31:0]   fwd;
  assign full      = count_q == (PW+1)'(DEPTH);
  assign sb_empty  = count_q == '0;
  assign enq       = MemWriteM && !full;
  assign deq       = !sb_empty && mem_ready;
  assign StallM    = MemWriteM && full;
  assign mem_we    = !sb_empty;
  assign mem_waddr = {addr_q[head_q], 2'b00};
  assign mem_wdata = data_q[head_q];
  assign mem_raddr = {ALUResultM[AW-1:2], 2'b00};
  assign ReadDataM = fwd;
  always_comb begin
    head_d  = deq ? head_q + 1'b1 : head_q;
    tail_d  = enq ? tail_q + 1'b1 : tail_q;
    count_d = (enq && !deq) ? count_q + 1'b1 : (deq && !enq) ? count_q - 1'b1 : count_q;
  end
  // Walk from oldest to youngest so later matches override; validity comes
  // from the offset against count, never from entry contents.
  always_comb begin
    fwd = mem_rdata;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(i) < count_q && addr_q[head_q + PW'(i)] == ALUResultM[AW-1:2])
        fwd = data_q[head_q + PW'(i)];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  // Entry payload is deliberately unreset; pointers alone define validity.
  always_ff @(posedge clk)
    if (enq) begin
      addr_q[tail_q] <= ALUResultM[AW-1:2];
      data_q[tail_q] <= WriteDataM;
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed table-driven check of store_buffer
module tb_store_buffer;
  logic        clk = 0, rst = 1, MemWriteM = 0, mem_ready = 0;
  logic [31:0] ALUResultM = 0, WriteDataM = 0, mem_rdata = 0;
  logic [31:0] ReadDataM, mem_waddr, mem_wdata, mem_raddr;
  logic        StallM, sb_empty, mem_we;
  int errors = 0, checks = 0;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .sb_empty(sb_empty), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr, wd;
    logic        rdy;
    logic [31:0] rdat;
    logic        e_stall, e_empty, e_we;
    logic [31:0] e_waddr, e_wdata, e_rd;
  } vec_t;
  vec_t v[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] rdat);
    MemWriteM = we; ALUResultM = addr; WriteDataM = wd; mem_ready = rdy; mem_rdata = rdat;
  endtask

  initial begin
    // {we, addr, wdata, ready, rdata, stall, empty, mem_we, waddr, wdata, ReadDataM}
    v.push_back('{0, 32'h44,  0,            1, 32'hAAAA0000, 0, 1, 0, 0,      0,            32'hAAAA0000});
    v.push_back('{1, 32'h100, 32'hDEADBEEF, 1, 32'h5,        0, 1, 0, 0,      0,            32'h5});
    v.push_back('{0, 32'h100, 0,            1, 32'h7,        0, 0, 1, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF});
    v.push_back('{0, 32'h100, 0,            1, 32'h7,        0, 1, 0, 0,      0,            32'h7});
    v.push_back('{1, 32'h0,   32'hA0,       0, 32'h9,        0, 1, 0, 0,      0,            32'h9});
    v.push_back('{1, 32'h4,   32'hA1,       0, 32'h9,        0, 0, 1, 32'h0,  32'hA0,       32'h9});
    v.push_back('{1, 32'h8,   32'hA2,       0, 32'h9,        0, 0, 1, 32'h0,  32'hA0,       32'h9});
    v.push_back('{1, 32'hC,   32'hA3,       0, 32'h9,        0, 0, 1, 32'h0,  32'hA0,       32'h9});
    v.push_back('{1, 32'h10,  32'hA4,       0, 32'h9,        1, 0, 1, 32'h0,  32'hA0,       32'h9});
    v.push_back('{1, 32'h10,  32'hA4,       0, 32'h9,        1, 0, 1, 32'h0,  32'hA0,       32'h9});
    v.push_back('{1, 32'h10,  32'hA4,       1, 32'h9,        1, 0, 1, 32'h0,  32'hA0,       32'h9});
    v.push_back('{1, 32'h10,  32'hA4,       0, 32'h9,        0, 0, 1, 32'h4,  32'hA1,       32'h9});
    v.push_back('{0, 32'h10,  0,            0, 32'h0,        0, 0, 1, 32'h4,  32'hA1,       32'hA4});
    v.push_back('{0, 32'hC,   0,            0, 32'h0,        0, 0, 1, 32'h4,  32'hA1,       32'hA3});
    v.push_back('{0, 32'h200, 0,            1, 32'h33,       0, 0, 1, 32'h4,  32'hA1,       32'h33});
    v.push_back('{1, 32'h14,  32'hA5,       1, 32'h33,       0, 0, 1, 32'h8,  32'hA2,       32'h33});
    v.push_back('{1, 32'h18,  32'hA6,       1, 32'h33,       0, 0, 1, 32'hC,  32'hA3,       32'h33});
    v.push_back('{0, 32'h200, 0,            1, 32'h33,       0, 0, 1, 32'h10, 32'hA4,       32'h33});
    v.push_back('{0, 32'h200, 0,            1, 32'h33,       0, 0, 1, 32'h14, 32'hA5,       32'h33});
    v.push_back('{0, 32'h200, 0,            1, 32'h33,       0, 0, 1, 32'h18, 32'hA6,       32'h33});
    v.push_back('{0, 32'h200, 0,            1, 32'h33,       0, 1, 0, 0,      0,            32'h33});
    v.push_back('{1, 32'h40,  32'h11111111, 0, 32'h0,        0, 1, 0, 0,      0,            32'h0});
    v.push_back('{1, 32'h40,  32'h22222222, 0, 32'h0,        0, 0, 1, 32'h40, 32'h11111111, 32'h11111111});
    v.push_back('{0, 32'h42,  0,            0, 32'h0,        0, 0, 1, 32'h40, 32'h11111111, 32'h22222222});
    v.push_back('{0, 32'h44,  0,            0, 32'h5A5A,     0, 0, 1, 32'h40, 32'h11111111, 32'h5A5A});
    v.push_back('{1, 32'h48,  32'h33,       0, 32'h0,        0, 0, 1, 32'h40, 32'h11111111, 32'h0});

    #2;
    check("reset mem_we", mem_we, 0);
    check("reset sb_empty", sb_empty, 1);
    check("reset StallM", StallM, 0);
    @(negedge clk);
    rst = 0;

    foreach (v[k]) begin
      drive(v[k].we, v[k].addr, v[k].wd, v[k].rdy, v[k].rdat);
      #2;
      check($sformatf("v%0d StallM", k), StallM, v[k].e_stall);
      check($sformatf("v%0d sb_empty", k), sb_empty, v[k].e_empty);
      check($sformatf("v%0d mem_we", k), mem_we, v[k].e_we);
      check($sformatf("v%0d ReadDataM", k), ReadDataM, v[k].e_rd);
      check($sformatf("v%0d mem_raddr", k), mem_raddr, {v[k].addr[31:2], 2'b00});
      if (v[k].e_we) begin
        check($sformatf("v%0d mem_waddr", k), mem_waddr, v[k].e_waddr);
        check($sformatf("v%0d mem_wdata", k), mem_wdata, v[k].e_wdata);
      end
      @(negedge clk);
    end

    // Three stores pending; asynchronous reset mid-cycle must drop them all.
    drive(0, 32'h40, 0, 1, 32'h77);
    #2;
    check("pre-reset mem_we", mem_we, 1);
    rst = 1;
    #1;
    check("midreset mem_we", mem_we, 0);
    check("midreset sb_empty", sb_empty, 1);
    check("midreset StallM", StallM, 0);
    check("midreset stale fwd", ReadDataM, 32'h77);
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      check($sformatf("post-reset idle %0d", c), mem_we, 0);
      @(negedge clk);
    end
    drive(1, 32'h80, 32'hCAFEF00D, 1, 32'h0);
    #2;
    check("new store not passthrough", mem_we, 0);
    @(negedge clk);
    drive(0, 32'h80, 0, 0, 32'h0);
    #2;
    check("new store mem_we", mem_we, 1);
    check("new store waddr", mem_waddr, 32'h80);
    check("new store wdata", mem_wdata, 32'hCAFEF00D);
    check("new store fwd", ReadDataM, 32'hCAFEF00D);
    @(negedge clk);
    #2;
    check("held mem_we", mem_we, 1);
    check("held waddr", mem_waddr, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular store buffer between the pipelined core's Memory stage and a single-port data memory with a valid/ready write handshake. Core stores retire into a DEPTH-entry FIFO in one cycle. The FIFO drains to memory in order. Loads are served from the memory read port, overridden by the youngest buffered store to the same word. It raises a stall to the hazard unit only when the buffer is full.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2
- AW, 32, byte-address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- MemWriteM  in  1  Memory-stage store request
- ALUResultM  in  AW  byte address for both loads and stores; bits [1:0] ignored
- WriteDataM  in  32  store data
- ReadDataM  out  32  load data to the core; combinational
- StallM  out  1  MemWriteM && full; the hazard unit freezes F/D/E/M while it is high
- sb_empty  out  1  count==0; used by fence handling
- mem_we  out  1  write valid to memory
- mem_waddr  out  AW  head entry address, word-aligned ([1:0]=0)
- mem_wdata  out  32  head entry data
- mem_ready  in  1  memory accepts the write this cycle
- mem_raddr  out  AW  ALUResultM with [1:0] forced to 0
- mem_rdata  in  32  asynchronous memory read data for mem_raddr

## Operation
- Storage: DEPTH entries of {word address AW-2 bits, data 32}, plus head pointer, tail pointer and count.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Enqueue: MemWriteM && !full → write {ALUResultM[AW-1:2], WriteDataM} at tail, then tail+1.
- Dequeue: mem_we = !empty. mem_waddr/mem_wdata always show the head entry. mem_we && mem_ready → head+1.
- Count update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both occur in the same cycle.
- Full with MemWriteM:
  - No enqueue occurs. StallM=1 and the core holds the store.
  - A dequeue in that cycle frees a slot. The held store enqueues the following cycle and StallM drops then.
  - There is no same-cycle bypass into a full buffer.
- Empty with MemWriteM: the store enqueues and appears on mem_we the next cycle. There is no direct pass-through to memory.
- Load forwarding is computed every cycle, independent of MemWriteM:
  - Compare ALUResultM[AW-1:2] against every valid entry.
  - ReadDataM = data of the youngest matching entry (closest to tail-1); otherwise mem_rdata.
  - The head entry being accepted this cycle still counts as valid for forwarding in this cycle.
- Store ordering: stores to the same address drain in program order. The buffer does not merge or coalesce entries.
- Reset (asynchronous, rst=1):
  - head=tail=count=0, so mem_we=0, StallM=0, sb_empty=1.
  - Entry contents are not reset. Forwarding must qualify matches by entry validity (position relative to head/count), never by stale data.
  - Reset mid-drain drops all pending stores. Memory sees no further writes until new stores arrive.

## Timing
- Store acceptance: 1 cycle (registered into the FIFO at the edge where MemWriteM && !full).
- Store-to-memory latency: the earliest mem_we for a store is the cycle after enqueue. The write completes on the first edge with mem_ready=1.
- Throughput with mem_ready tied high: one store per cycle sustained, and the buffer never fills.
- ReadDataM, StallM, sb_empty, mem_* outputs: combinational from state and current inputs; no registered output delay.
- mem_we must stay asserted, with stable address and data, until mem_ready. The head changes only on handshake.

## Test plan
- Reset and idle: assert rst mid-cycle → mem_we=0, sb_empty=1, StallM=0 immediately. ReadDataM follows mem_rdata.
- Single store, mem_ready=1: sw 0xDEADBEEF to 0x100 → next cycle mem_we=1, mem_waddr=0x100, mem_wdata=0xDEADBEEF. The cycle after that, sb_empty=1.
- Fill and stall: mem_ready=0, issue 5 stores to 0x0, 0x4, 0x8, 0xC, 0x10 →
  - After 4 enqueues, the 5th cycle shows StallM=1 and count stays 4.
  - Raise mem_ready for 1 cycle → 0x0 drains, 0x10 enqueues next edge, StallM=0.
- Forwarding youngest: with mem_ready=0, store 0x11111111 then 0x22222222 to 0x40. Load 0x42 with mem_rdata=0x0 → ReadDataM=0x22222222. Load 0x44 → ReadDataM=mem_rdata.
- Simultaneous enqueue and dequeue: count=2, mem_ready=1, MemWriteM=1 → count stays 2, head and tail both advance. Data order on mem_wdata is preserved across the pointer wrap at DEPTH.
- Reset mid-drain: 3 stores pending, assert rst → mem_we=0 immediately. After release, no writes appear until a new store is issued.
